pixel_buffer: RTL and testbench

Double-buffered grayscale image store that sits directly upstream of the VGA driver. It accepts a WIDTH×HEIGHT 8-bit image as a valid/ready raster stream from the classifier datapath. At a frame boundary it swaps the completed image to the display bank. It answers the driver's (x, y) pixel requests with r = g = b = stored pixel, one cycle later. Pixels outside the image, and all pixels before the first completed frame, read as black.

---
 rtl/pixel_buffer_pkg.sv | 15 +
 rtl/pixel_ram.sv | 26 ++
 rtl/pixel_buffer.sv | 126 ++++++++++++
 tb/tb_pixel_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_buffer_pkg.sv
// Shared types and helpers for the pixel_buffer double-buffered image store.
package pixel_buffer_pkg;

    localparam int unsigned PIX_W = 8;

    typedef enum logic {
        FILL,
        PENDING
    } state_e;

    function automatic int unsigned addr_width(input int unsigned npix);
        return (npix > 1) ? $clog2(npix) : 1;
    endfunction

endpackage

// File: rtl/pixel_ram.sv
// Simple dual-port RAM: one write port, one registered read port (block-RAM style).
module pixel_ram
    import pixel_buffer_pkg::*;
#(
    parameter int unsigned AddrW = 11
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [PIX_W-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [PIX_W-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** AddrW;

    logic [PIX_W-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/pixel_buffer.sv
// Double-buffered grayscale frame store feeding the VGA driver; swaps banks only at
// frame_start once a complete frame has been received.
module pixel_buffer
    import pixel_buffer_pkg::*;
#(
    parameter int unsigned WIDTH  = 28,
    parameter int unsigned HEIGHT = 28
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_last,
    input  logic             frame_start,
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    output logic [PIX_W-1:0] r,
    output logic [PIX_W-1:0] g,
    output logic [PIX_W-1:0] b,
    output logic             frame_err,
    output logic             have_frame
);

    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int unsigned AW   = addr_width(NPIX);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [9:0]    WIDTH_C   = 10'(WIDTH);
    localparam logic [8:0]    HEIGHT_C  = 9'(HEIGHT);

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic            front_q, front_d;
    logic            have_frame_q, have_frame_d;
    logic            frame_err_q, frame_err_d;
    logic            rdy_q;
    logic            in_range_q, in_range_d;

    logic            xfer;
    logic [AW-1:0]   rd_pix;
    logic [PIX_W-1:0] ram_q;
    logic [PIX_W-1:0] pix_out;

    assign in_ready = rdy_q;
    assign xfer     = in_valid & rdy_q;

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        front_d      = front_q;
        have_frame_d = have_frame_q;
        frame_err_d  = frame_err_q;
        unique case (state_q)
            FILL: begin
                if (xfer) begin
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d   = PENDING;
                        wr_addr_d = '0;
                        if (!in_last) begin
                            frame_err_d = 1'b1;
                        end
                    end else if (in_last) begin
                        // Short frame: drop it and restart; display bank is untouched.
                        frame_err_d = 1'b1;
                        wr_addr_d   = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            PENDING: begin
                if (frame_start) begin
                    front_d      = ~front_q;
                    have_frame_d = 1'b1;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q      <= FILL;
            wr_addr_q    <= '0;
            front_q      <= 1'b0;
            have_frame_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rdy_q        <= 1'b0;
            in_range_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            front_q      <= front_d;
            have_frame_q <= have_frame_d;
            frame_err_q  <= frame_err_d;
            rdy_q        <= (state_d == FILL);
            in_range_q   <= in_range_d;
        end
    end

    // Out-of-range coordinates may alias inside the bank; the in-range flag masks them.
    assign rd_pix     = AW'(y) * AW'(WIDTH) + AW'(x);
    assign in_range_d = (x < WIDTH_C) && (y < HEIGHT_C) && have_frame_q;

    // Bank bit is prepended, so the RAM spans 2**(AW+1) words.
    pixel_ram #(
        .AddrW (AW + 1)
    ) u_ram (
        .clk_i   (CLOCK_50),
        .we_i    (xfer),
        .waddr_i ({~front_q, wr_addr_q}),
        .wdata_i (in_data),
        .raddr_i ({front_q, rd_pix}),
        .rdata_o (ram_q)
    );

    assign pix_out    = in_range_q ? ram_q : '0;
    assign r          = pix_out;
    assign g          = pix_out;
    assign b          = pix_out;
    assign frame_err  = frame_err_q;
    assign have_frame = have_frame_q;

endmodule

// File: tb/tb_pixel_buffer.sv
// Randomized scoreboard bench for pixel_buffer against a frame-level reference model.
module tb_pixel_buffer;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int NPIX = W * H;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       frame_start;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r, g, b;
    logic       frame_err;
    logic       have_frame;

    always #5 CLOCK_50 = ~CLOCK_50;

    pixel_buffer #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .frame_start (frame_start),
        .x           (x),
        .y           (y),
        .r           (r),
        .g           (g),
        .b           (b),
        .frame_err   (frame_err),
        .have_frame  (have_frame)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];

    // Reference model: whole images as arrays, no banks or address counters.
    logic [7:0] m_disp [NPIX];
    logic [7:0] m_pend [NPIX];
    logic [7:0] m_fill [NPIX];
    int         m_cnt     = 0;
    bit         m_pending = 0;
    bit         m_have    = 0;
    bit         m_err     = 0;
    bit         m_rdy     = 0;
    bit         m_xfer    = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] model_read();
        int xi = int'(x);
        int yi = int'(y);
        if (!reset || !m_have || xi >= W || yi >= H) return 8'd0;
        return m_disp[yi * W + xi];
    endfunction

    task automatic tick();
        bit swap;
        exp_q.push_back(model_read());
        @(posedge CLOCK_50);
        if (!reset) begin
            m_pending = 0;
            m_cnt     = 0;
            m_have    = 0;
            m_err     = 0;
            m_rdy     = 0;
            m_xfer    = 0;
        end else begin
            swap   = frame_start && m_pending;
            m_xfer = in_valid && m_rdy;
            if (m_xfer) begin
                m_fill[m_cnt] = in_data;
                m_cnt++;
                if (m_cnt == NPIX) begin
                    m_pend    = m_fill;
                    m_pending = 1;
                    m_cnt     = 0;
                    if (!in_last) m_err = 1;
                end else if (in_last) begin
                    m_err = 1;
                    m_cnt = 0;
                end
            end
            if (swap) begin
                m_disp    = m_pend;
                m_have    = 1;
                m_pending = 0;
            end
            m_rdy = !m_pending;
        end
        #1;
        check("in_ready", int'(in_ready), int'(m_rdy));
        check("have_frame", int'(have_frame), int'(m_have));
        check("frame_err", int'(frame_err), int'(m_err));
    endtask

    // Monitor: every cycle the DUT presents the pixel for the previous cycle's (x, y).
    logic [7:0] mon_exp;
    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("rd_r", int'(r), int'(mon_exp));
                check("rd_g", int'(g), int'(mon_exp));
                check("rd_b", int'(b), int'(mon_exp));
            end
        end
    end

    task automatic rand_rd();
        case ($urandom % 8)
            0: begin
                x = 10'($urandom_range(28, 1023));
                y = 9'($urandom_range(0, 511));
            end
            1: begin
                x = 10'($urandom_range(0, 27));
                y = 9'($urandom_range(28, 511));
            end
            default: begin
                x = 10'($urandom_range(0, 27));
                y = 9'($urandom_range(0, 27));
            end
        endcase
    endtask

    task automatic idle(input int n);
        in_valid    = 1'b0;
        in_last     = 1'b0;
        frame_start = 1'b0;
        repeat (n) begin
            rand_rd();
            tick();
        end
    endtask

    task automatic read_at(input int xi, input int yi);
        in_valid    = 1'b0;
        frame_start = 1'b0;
        x           = 10'(xi);
        y           = 9'(yi);
        tick();
    endtask

    task automatic pulse_fs();
        in_valid    = 1'b0;
        frame_start = 1'b1;
        rand_rd();
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b0;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        repeat (n) begin
            rand_rd();
            tick();
        end
        reset = 1'b1;
    endtask

    // mode 0: i mod 256, 1: 0xAA, 2: random. Stray frame_start pulses are mixed in.
    task automatic send_frame(input int n, input int mode, input bit with_last,
                              input bit fs_on_last);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < n * 8 + 100) begin
            bit at_last = (sent == n - 1);
            in_valid = (($urandom % 4) != 0) || (at_last && fs_on_last);
            case (mode)
                0:       in_data = 8'(sent % 256);
                1:       in_data = 8'hAA;
                default: in_data = 8'($urandom);
            endcase
            in_last     = in_valid ? (with_last && at_last) : 1'($urandom);
            frame_start = (fs_on_last && at_last) ? 1'b1 : (($urandom % 16) == 0);
            rand_rd();
            tick();
            if (m_xfer) sent++;
            guard++;
        end
        check("send_progress", sent, n);
        in_valid    = 1'b0;
        in_last     = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        in_last     = 1'b0;
        frame_start = 1'b0;
        x           = 10'd0;
        y           = 9'd0;

        // Reset for 3 cycles, then in_ready rises one cycle after release.
        do_reset(3);
        idle(2);

        // Fill with i mod 256 and swap; (5,2) reads 61, (28,0) reads black.
        send_frame(NPIX, 0, 1'b1, 1'b0);
        idle(2);
        pulse_fs();
        read_at(5, 2);
        read_at(28, 0);
        read_at(27, 27);
        read_at(0, 28);

        // Frame 2 of 0xAA stays hidden until the next frame_start.
        send_frame(NPIX, 1, 1'b1, 1'b0);
        idle(3);
        pulse_fs();
        idle(20);

        // Early in_last: error, partial frame dropped, display unchanged.
        do_reset(2);
        send_frame(NPIX, 2, 1'b1, 1'b0);
        pulse_fs();
        send_frame(101, 2, 1'b1, 1'b0);
        idle(20);
        send_frame(NPIX, 2, 1'b1, 1'b0);
        idle(2);
        pulse_fs();
        idle(20);

        // Missing in_last: error but the frame still swaps.
        do_reset(2);
        send_frame(NPIX, 2, 1'b0, 1'b0);
        idle(3);
        pulse_fs();
        idle(20);

        // Last pixel coincident with frame_start: swap waits for the next pulse.
        do_reset(2);
        send_frame(NPIX, 2, 1'b1, 1'b1);
        idle(5);
        pulse_fs();
        idle(20);

        // Reset mid-fill after 300 pixels; a full frame is needed afterwards.
        send_frame(300, 2, 1'b0, 1'b0);
        do_reset(2);
        send_frame(NPIX, 2, 1'b1, 1'b0);
        idle(2);
        pulse_fs();
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
